// File: rtl/tx_gpack.sv
// Shared constants, state encoding and mode encoding for the transmit datapath.
package tx_gpack;

  localparam int TAPS_DEF     = 3;
  localparam int WEIGHT_W_DEF = 8;
  localparam int OUT_W_DEF    = WEIGHT_W_DEF + 2;
  localparam int PRE_LEN_DEF  = 16;

  // x^7 + x^6 + 1: feedback from state bits 6 and 5
  localparam logic [6:0] PRBS_SEED   = 7'h7F;
  localparam int         PRBS_TAP_HI = 6;
  localparam int         PRBS_TAP_LO = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    RUN      = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  localparam logic [1:0] MODE_ZERO = 2'd0;
  localparam logic [1:0] MODE_PRBS = 2'd1;
  localparam logic [1:0] MODE_USER = 2'd2;
  localparam logic [1:0] MODE_ALT  = 2'd3;

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 source: bit_o is the current MSB, the register shifts only when adv is high.
module prbs7_gen
  import tx_gpack::*;
(
  input  logic clk,
  input  logic rstb,
  input  logic adv,
  output logic bit_o
);

  logic [6:0] r_state;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= PRBS_SEED;
    end else if (adv) begin
      r_state <= {r_state[5:0], r_state[PRBS_TAP_HI] ^ r_state[PRBS_TAP_LO]};
    end
  end

  assign bit_o = r_state[6];

endmodule

// File: rtl/tx_datapath.sv
// Serial transmit datapath: preamble/pattern/user-data bit source feeding a
// post-cursor FIR with double-buffered tap weights and a two-stage output pipeline.
module tx_datapath
  import tx_gpack::*;
#(
  parameter  int TAPS     = TAPS_DEF,
  parameter  int WEIGHT_W = WEIGHT_W_DEF,
  parameter  int PRE_LEN  = PRE_LEN_DEF,
  localparam int OUT_W    = WEIGHT_W + 2
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       data_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  input  logic                       wt_wr,
  input  logic [1:0]                 wt_addr,
  input  logic signed [WEIGHT_W-1:0] wt_data,
  input  logic                       wt_commit,
  output logic signed [OUT_W-1:0]    tx_code_o,
  output logic                       tx_bit_o,
  output logic                       tx_valid_o,
  output logic                       underflow_o
);

  localparam int                CNT_W       = $clog2(PRE_LEN + TAPS + 1);
  localparam logic [CNT_W-1:0]  PRE_LAST    = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0]  FLUSH_LAST  = CNT_W'((TAPS > 1) ? TAPS - 2 : 0);
  localparam logic signed [WEIGHT_W-1:0] WT_MAIN_RST = {2'b01, {(WEIGHT_W-2){1'b0}}};

  state_e              r_state;
  logic [1:0]          r_mode;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_alt;
  logic                r_ready;
  logic                r_uf;

  logic [TAPS-1:0]             r_dl_bit;
  logic [TAPS-1:0]             r_dl_act;
  logic signed [WEIGHT_W-1:0]  r_wt_shadow [TAPS];
  logic signed [WEIGHT_W-1:0]  r_wt_active [TAPS];
  logic signed [OUT_W-1:0]     r_code;
  logic                        r_bit;
  logic                        r_valid;

  logic                    w_emit;
  logic                    w_bit;
  logic                    w_prbs_adv;
  logic                    w_prbs_bit;
  logic                    w_alt_adv;
  logic                    w_wr_ok;
  logic signed [OUT_W-1:0] w_fir;
  logic                    w_any_act;

  assign w_emit     = (r_state == PREAMBLE) || (r_state == RUN);
  assign w_prbs_adv = (r_state == RUN) && (r_mode == MODE_PRBS);
  assign w_alt_adv  = (r_state == PREAMBLE) || ((r_state == RUN) && (r_mode == MODE_ALT));
  assign w_wr_ok    = wt_wr && (int'(wt_addr) < TAPS);

  prbs7_gen u_prbs (
    .clk   (clk),
    .rstb  (rstb),
    .adv   (w_prbs_adv),
    .bit_o (w_prbs_bit)
  );

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_bit = 1'b0;
    if (r_state == PREAMBLE) begin
      w_bit = r_alt;
    end else if (r_state == RUN) begin
      case (r_mode)
        MODE_PRBS: w_bit = w_prbs_bit;
        MODE_USER: w_bit = data_valid_i & data_i;
        MODE_ALT:  w_bit = r_alt;
        default:   w_bit = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= IDLE;
      r_mode  <= MODE_ZERO;
      r_cnt   <= '0;
      r_alt   <= 1'b1;
      r_ready <= 1'b0;
      r_uf    <= 1'b0;
    end else begin
      if (w_alt_adv) r_alt <= ~r_alt;
      if ((r_state == RUN) && (r_mode == MODE_USER) && !data_valid_i) r_uf <= 1'b1;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state <= PREAMBLE;
            r_mode  <= mode;
            r_cnt   <= '0;
            r_alt   <= 1'b1;
            r_uf    <= 1'b0;
          end
        end
        PREAMBLE: begin
          if (!en) begin
            r_cnt <= '0;
            if (TAPS > 1) r_state <= FLUSH;
            else          r_state <= IDLE;
          end else if (r_cnt == PRE_LAST) begin
            r_state <= RUN;
            r_ready <= (r_mode == MODE_USER);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            r_cnt   <= '0;
            r_ready <= 1'b0;
            if (TAPS > 1) r_state <= FLUSH;
            else          r_state <= IDLE;
          end
        end
        FLUSH: begin
          // en is ignored here; a held en re-enters PREAMBLE via one IDLE cycle
          if (r_cnt == FLUSH_LAST) r_state <= IDLE;
          else                     r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the weight arrays are reset explicitly because tap 0 must come up at unity gain.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < TAPS; k++) begin
        r_wt_shadow[k] <= (k == 0) ? WT_MAIN_RST : '0;
        r_wt_active[k] <= (k == 0) ? WT_MAIN_RST : '0;
      end
      r_dl_bit <= '0;
      r_dl_act <= '0;
      r_code   <= '0;
      r_bit    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (w_wr_ok && (int'(wt_addr) == k)) r_wt_shadow[k] <= wt_data;
        // a write in the commit cycle bypasses the shadow so the new value lands at once
        if (wt_commit) begin
          r_wt_active[k] <= (w_wr_ok && (int'(wt_addr) == k)) ? wt_data : r_wt_shadow[k];
        end
      end
      r_dl_bit[0] <= w_bit & w_emit;
      r_dl_act[0] <= w_emit;
      for (int k = 1; k < TAPS; k++) begin
        r_dl_bit[k] <= r_dl_bit[k-1];
        r_dl_act[k] <= r_dl_act[k-1];
      end
      r_code  <= w_fir;
      r_bit   <= r_dl_bit[0] & r_dl_act[0];
      r_valid <= w_any_act;
    end
  end

  always_comb begin
    w_fir     = '0;
    w_any_act = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      if (r_dl_act[k]) begin
        w_any_act = 1'b1;
        if (r_dl_bit[k]) w_fir = w_fir + OUT_W'(r_wt_active[k]);
        else             w_fir = w_fir - OUT_W'(r_wt_active[k]);
      end
    end
  end

  assign tx_code_o    = r_code;
  assign tx_bit_o     = r_bit;
  assign tx_valid_o   = r_valid;
  assign data_ready_o = r_ready;
  assign underflow_o  = r_uf;

endmodule

// File: tb/tb_tx_datapath.sv
// Bench for tx_datapath: directed preamble/PRBS and reset sequences, then randomized
// burst tables whose expected outputs come from a symbol-stream convolution model.
module tb_tx_datapath;
  import tx_gpack::*;

  localparam int TAPS = 3;
  localparam int WW   = 8;
  localparam int PRE  = 16;
  localparam int OW   = WW + 2;
  localparam int MAXC = 2000;

  logic                 clk = 1'b0;
  logic                 rstb = 1'b0;
  logic                 en = 1'b0;
  logic [1:0]           mode = 2'd0;
  logic                 data_i = 1'b0;
  logic                 data_valid_i = 1'b0;
  logic                 wt_wr = 1'b0;
  logic [1:0]           wt_addr = 2'd0;
  logic signed [WW-1:0] wt_data = '0;
  logic                 wt_commit = 1'b0;
  logic                 data_ready_o;
  logic signed [OW-1:0] tx_code_o;
  logic                 tx_bit_o;
  logic                 tx_valid_o;
  logic                 underflow_o;

  tx_datapath #(.TAPS(TAPS), .WEIGHT_W(WW), .PRE_LEN(PRE)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .en           (en),
    .mode         (mode),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .wt_wr        (wt_wr),
    .wt_addr      (wt_addr),
    .wt_data      (wt_data),
    .wt_commit    (wt_commit),
    .tx_code_o    (tx_code_o),
    .tx_bit_o     (tx_bit_o),
    .tx_valid_o   (tx_valid_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [1:0]    mode;
    logic          dv;
    logic          di;
    logic          wr;
    logic [1:0]    addr;
    logic [WW-1:0] wdata;
    logic          commit;
    logic          act;
    logic          b;
    int            code;
    logic          ebit;
    logic          evalid;
    logic          eready;
    logic          euf;
  } vec_t;

  vec_t vt [MAXC];
  int   weff [MAXC][4];
  int   nv;
  int   n_checks = 0;
  int   n_pass = 0;
  int   m_shadow [4];
  int   m_active [4];
  int   m_prbs_idx;
  logic m_uf;
  logic prbs_seq [127];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int wrap(input int v);
    logic signed [OW-1:0] t;
    t = OW'(v);
    return int'(t);
  endfunction

  task automatic model_reset();
    m_shadow   = '{64, 0, 0, 0};
    m_active   = '{64, 0, 0, 0};
    m_prbs_idx = 0;
    m_uf       = 1'b0;
  endtask

  task automatic idle_inputs();
    en = 1'b0; mode = 2'd0; data_i = 1'b0; data_valid_i = 1'b0;
    wt_wr = 1'b0; wt_addr = 2'd0; wt_data = '0; wt_commit = 1'b0;
  endtask

  // kind: 0 = no symbol emitted, 1 = preamble symbol j, 2 = payload symbol j
  task automatic add_cycle(input logic en_i, input int kind, input logic [1:0] bmode,
                           input int j, input logic start);
    vec_t v;
    v.en     = en_i;
    v.mode   = start ? bmode : 2'($urandom_range(0, 3));
    v.dv     = 1'($urandom_range(0, 1));
    v.di     = 1'($urandom_range(0, 1));
    v.wr     = ($urandom_range(0, 5) == 0);
    v.addr   = 2'($urandom_range(0, 3));
    v.wdata  = WW'($urandom);
    v.commit = ($urandom_range(0, 7) == 0);
    v.eready = (kind == 2) && (bmode == MODE_USER);
    v.euf    = m_uf;
    v.act    = (kind != 0);
    v.b      = 1'b0;
    v.code   = 0;
    v.ebit   = 1'b0;
    v.evalid = 1'b0;
    weff[nv] = m_active;
    if (kind == 1) begin
      v.b = (j % 2 == 0);
    end else if (kind == 2) begin
      case (bmode)
        MODE_PRBS: begin
          v.b = prbs_seq[m_prbs_idx % 127];
          m_prbs_idx++;
        end
        MODE_USER: begin
          v.b = v.dv & v.di;
          if (!v.dv) m_uf = 1'b1;
        end
        MODE_ALT: v.b = (j % 2 == 0);
        default:  v.b = 1'b0;
      endcase
    end
    if (start) m_uf = 1'b0;
    if (v.wr && (int'(v.addr) < TAPS)) m_shadow[v.addr] = int'($signed(v.wdata));
    if (v.commit) m_active = m_shadow;
    if (nv < MAXC) begin
      vt[nv] = v;
      nv++;
    end
  endtask

  task automatic build_table(input int nb);
    nv = 0;
    for (int b = 0; b < nb; b++) begin
      logic [1:0] bm;
      int         len;
      int         gap;
      logic       efl;
      bm  = (b == 0) ? MODE_PRBS : (b == 1) ? MODE_USER : 2'($urandom_range(0, 3));
      len = (b < 2) ? PRE + 12 : $urandom_range(1, PRE + 24);
      gap = $urandom_range(0, 2);
      efl = 1'($urandom_range(0, 1));
      for (int g = 0; g < gap; g++) add_cycle(1'b0, 0, bm, 0, 1'b0);
      add_cycle(1'b1, 0, bm, 0, 1'b1);
      for (int j = 0; j < len; j++) add_cycle(j < len - 1, (j < PRE) ? 1 : 2, bm, j, 1'b0);
      for (int f = 0; f < TAPS - 1; f++) add_cycle(efl, 0, bm, 0, 1'b0);
    end
    for (int g = 0; g < TAPS + 3; g++) add_cycle(1'b0, 0, 2'd0, 0, 1'b0);
    // output at cycle c convolves symbols from c-2-k with weights active during c-1
    for (int c = 0; c < nv; c++) begin
      int   code;
      logic valid;
      code  = 0;
      valid = 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        int e;
        e = c - 2 - k;
        if (e >= 0 && vt[e].act) begin
          valid = 1'b1;
          code  = vt[e].b ? code + weff[c-1][k] : code - weff[c-1][k];
        end
      end
      vt[c].code   = wrap(code);
      vt[c].evalid = valid;
      vt[c].ebit   = (c >= 2 && vt[c-2].act) ? vt[c-2].b : 1'b0;
    end
  endtask

  task automatic run_table(input string tag);
    for (int c = 0; c < nv; c++) begin
      @(negedge clk);
      check($sformatf("%s code@%0d", tag, c), int'(tx_code_o), vt[c].code);
      check($sformatf("%s bit@%0d", tag, c), int'(tx_bit_o), int'(vt[c].ebit));
      check($sformatf("%s valid@%0d", tag, c), int'(tx_valid_o), int'(vt[c].evalid));
      check($sformatf("%s ready@%0d", tag, c), int'(data_ready_o), int'(vt[c].eready));
      check($sformatf("%s underflow@%0d", tag, c), int'(underflow_o), int'(vt[c].euf));
      en           = vt[c].en;
      mode         = vt[c].mode;
      data_valid_i = vt[c].dv;
      data_i       = vt[c].di;
      wt_wr        = vt[c].wr;
      wt_addr      = vt[c].addr;
      wt_data      = vt[c].wdata;
      wt_commit    = vt[c].commit;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    int pre_codes [4];
    int len;
    pre_codes = '{64, -80, 80, -80};
    for (int n = 0; n < 127; n++) prbs_seq[n] = (n < 7) ? 1'b1 : (prbs_seq[n-7] ^ prbs_seq[n-6]);
    model_reset();

    repeat (3) @(negedge clk);
    check("rst code", int'(tx_code_o), 0);
    check("rst bit", int'(tx_bit_o), 0);
    check("rst valid", int'(tx_valid_o), 0);
    check("rst ready", int'(data_ready_o), 0);
    check("rst underflow", int'(underflow_o), 0);
    rstb = 1'b1;

    // w1 = -16 via simultaneous write+commit; write to tap 3 must be dropped
    @(negedge clk);
    wt_wr = 1'b1; wt_addr = 2'd1; wt_data = -8'sd16; wt_commit = 1'b1;
    @(negedge clk);
    wt_addr = 2'd3; wt_data = 8'sd99;
    @(negedge clk);
    idle_inputs();
    m_shadow[1] = -16;
    m_active[1] = -16;

    len = PRE + 12;
    @(negedge clk);
    en = 1'b1; mode = MODE_PRBS;
    for (int t = 1; t <= len + TAPS + 3; t++) begin
      int j;
      @(negedge clk);
      j = t - 3;
      if (t < 3) check($sformatf("pre valid@%0d", t), int'(tx_valid_o), 0);
      if (j >= 0 && j < 4) check($sformatf("pre code%0d", j), int'(tx_code_o), pre_codes[j]);
      if (j >= 0 && j < len)
        check($sformatf("pre/prbs bit%0d", j), int'(tx_bit_o),
              (j < PRE) ? int'(j % 2 == 0) : int'(prbs_seq[j - PRE]));
      en   = (t < len);
      mode = 2'($urandom_range(0, 3));
    end
    check("drained valid", int'(tx_valid_o), 0);
    check("drained code", int'(tx_code_o), 0);
    mode = 2'd0;
    m_prbs_idx = 12;

    build_table(12);
    run_table("t1");

    // abort mid-RUN with an asynchronous reset pulse
    @(negedge clk);
    en = 1'b1; mode = MODE_PRBS;
    repeat (PRE + 8) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    check("midrst code", int'(tx_code_o), 0);
    check("midrst bit", int'(tx_bit_o), 0);
    check("midrst valid", int'(tx_valid_o), 0);
    check("midrst ready", int'(data_ready_o), 0);
    check("midrst underflow", int'(underflow_o), 0);
    @(negedge clk);
    rstb = 1'b1;
    idle_inputs();
    model_reset();

    build_table(12);
    run_table("t2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
